alu16: RTL and testbench
========================

# alu16

Registered 16-bit, four-function arithmetic/logic unit. It takes two 16-bit operands and a 2-bit operation select, and produces a 16-bit result one clock later. It has optional status flags and is intended as the datapath ALU leaf inside larger 16-bit processing blocks.

## Interface
- Parameters: none; width is fixed at 16.
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in1  in  16  operand A, unsigned or two's complement.
- in2  in  16  operand B.
- sel  in  2  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR.
- in_valid  in  1  operands and sel are sampled when high.
- out  out  16  registered result.
- out_valid  out  1  high for one cycle per accepted operation.
- carry  out  1  ADD: carry-out; SUB: borrow-free indicator (in1 >= in2, unsigned); 0 for logic ops.
- overflow  out  1  signed overflow for ADD/SUB; 0 for logic ops.
- zero  out  1  out == 16'h0000.
- negative  out  1  out[15].

## Operation
- ADD: out = (in1 + in2) mod 2^16. carry = bit 16 of the 17-bit sum.
- SUB: out = (in1 - in2) mod 2^16, computed as in1 + ~in2 + 1. carry = bit 16 of that sum, so 1 means no borrow.
- AND: out = in1 & in2. OR: out = in1 | in2.
- overflow for ADD: operands have the same sign and the result sign differs.
- overflow for SUB: operands have different signs and the result sign differs from in1.
- zero and negative are derived from the registered result for every op.
- When in_valid is low: out and all flags hold their previous values, and out_valid is 0.
- Every sel encoding is defined; there is no illegal opcode.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N with in_valid=1 appear on out/flags after edge N, with out_valid=1 for that cycle.
- Throughput is one operation per cycle; back-to-back valid inputs produce back-to-back results.
- There is no backpressure; the consumer must accept out_valid when asserted.
- Reset: at an edge with rst=1, out=0, carry=0, overflow=0, negative=0, zero=1, out_valid=0.
- rst has priority over in_valid; an operation presented in the reset cycle is discarded.
- Inputs changing mid-cycle have no effect; only edge-sampled values matter.

## Configuration
- Macro ALU16_FLAGS_EN.
- Defined: carry, overflow, zero and negative are computed and registered as specified above.
- Undefined: the flag ports remain on the interface but are driven constant 0, and their flag logic and registers are not synthesized. out and out_valid are unaffected.

## Structure
- Shared package alu16_pkg holds:
  - the opcode enum alu16_op_e (ALU16_ADD=2'd0, ALU16_SUB=2'd1, ALU16_AND=2'd2, ALU16_OR=2'd3);
  - the localparam ALU16_W=16.
- One sub-module, alu16_addsub: a combinational 17-bit adder with a subtract control that inverts B and sets carry-in. It outputs sum[15:0], cout and ovf. The top level holds the op mux and the output registers.

## Test plan
- Reset: rst=1 for 2 cycles -> out=0, out_valid=0, zero=1, other flags 0.
- Sel sweep: in1=400, in2=123, valid sel 0,1,2,3 on consecutive cycles -> results 523, 277, 0x0010 (400&123=16), 0x01FB (507), each one cycle later, with out_valid high on 4 consecutive cycles.
- ADD wrap: in1=0xFFFF, in2=0x0001, ADD -> out=0, carry=1, zero=1, overflow=0.
- Signed overflow: in1=0x7FFF, in2=0x0001, ADD -> out=0x8000, overflow=1, negative=1, carry=0. Then SUB with in1=0x8000, in2=1 -> out=0x7FFF, overflow=1.
- SUB borrow: in1=5, in2=7 -> out=0xFFFE, carry=0, negative=1. Swapped (in1=7, in2=5) -> out=2, carry=1.
- Hold and reset priority: in_valid=0 -> out and flags hold, out_valid=0. rst=1 together with in_valid=1 -> reset values, result discarded.

Source files
------------

// File: rtl/alu16_pkg.sv
// Shared opcode and width definitions for the alu16 datapath ALU.
// Status flags are enabled by defining ALU16_FLAGS_EN (see alu16.sv).
package alu16_pkg;

  localparam int ALU16_W = 16;

  typedef enum logic [1:0] {
    ALU16_ADD = 2'd0,
    ALU16_SUB = 2'd1,
    ALU16_AND = 2'd2,
    ALU16_OR  = 2'd3
  } alu16_op_e;

endpackage

// File: rtl/alu16_addsub.sv
// Combinational 17-bit adder/subtractor; subtraction inverts b and injects carry-in.
// Produces the 16-bit sum, carry-out (no-borrow when subtracting) and signed overflow.
module alu16_addsub
  import alu16_pkg::*;
(
  input  logic [ALU16_W-1:0] a,
  input  logic [ALU16_W-1:0] b,
  input  logic               sub,
  output logic [ALU16_W-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  logic [ALU16_W-1:0] bEff;
  logic [ALU16_W:0]   fullSum;

  assign bEff    = sub ? ~b : b;
  assign fullSum = {1'b0, a} + {1'b0, bEff} + {{ALU16_W{1'b0}}, sub};
  assign sum     = fullSum[ALU16_W-1:0];
  assign cout    = fullSum[ALU16_W];

  // Overflow when both adder inputs share a sign that the sum does not.
  assign ovf = (a[ALU16_W-1] == bEff[ALU16_W-1]) && (sum[ALU16_W-1] != a[ALU16_W-1]);

endmodule

// File: rtl/alu16.sv
// Registered 16-bit ADD/SUB/AND/OR unit with one-cycle latency.
// Define ALU16_FLAGS_EN to build the carry/overflow/zero/negative flags; otherwise they tie to 0.
module alu16
  import alu16_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ALU16_W-1:0] in1,
  input  logic [ALU16_W-1:0] in2,
  input  logic [1:0]         sel,
  input  logic               in_valid,
  output logic [ALU16_W-1:0] out,
  output logic               out_valid,
  output logic               carry,
  output logic               overflow,
  output logic               zero,
  output logic               negative
);

  alu16_op_e          op;
  logic [ALU16_W-1:0] addSum;
  logic               addCout;
  logic               addOvf;
  logic [ALU16_W-1:0] outData_d;
  logic [ALU16_W-1:0] outData_q;
  logic               outValid_q;

  assign op = alu16_op_e'(sel);

  alu16_addsub uAddSub (
    .a    (in1),
    .b    (in2),
    .sub  (op == ALU16_SUB),
    .sum  (addSum),
    .cout (addCout),
    .ovf  (addOvf)
  );

  always_comb begin
    outData_d = addSum;
    case (op)
      ALU16_AND: outData_d = in1 & in2;
      ALU16_OR:  outData_d = in1 | in2;
      default:   outData_d = addSum;
    endcase
  end

  // Result holds while idle; out_valid pulses only for accepted operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      outValid_q <= in_valid;
      if (in_valid) begin
        outData_q <= outData_d;
      end
    end
  end

  assign out       = outData_q;
  assign out_valid = outValid_q;

`ifdef ALU16_FLAGS_EN
  logic isArith;
  logic carry_d;
  logic carry_q;
  logic ovf_d;
  logic ovf_q;

  assign isArith = (op == ALU16_ADD) || (op == ALU16_SUB);
  assign carry_d = isArith & addCout;
  assign ovf_d   = isArith & addOvf;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (in_valid) begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // zero and negative follow the registered result, so reset yields zero=1.
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = (outData_q == '0);
  assign negative = outData_q[ALU16_W-1];
`else
  logic unusedFlags;

  assign unusedFlags = addCout ^ addOvf;
  assign carry       = 1'b0;
  assign overflow    = 1'b0;
  assign zero        = 1'b0;
  assign negative    = 1'b0;
`endif

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed vector table plus randomized traffic against a reference model.
// Flag expectations follow ALU16_FLAGS_EN (flags expected 0 when it is undefined).
module tb_alu16;

`ifdef ALU16_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  sel;
    logic [15:0] expOut;
    logic        expValid;
    logic        expCarry;
    logic        expOvf;
    logic        expZero;
    logic        expNeg;
  } vector_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [1:0]  sel;
  logic        in_valid;
  logic [15:0] out;
  logic        out_valid;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;

  int errors = 0;
  int checks = 0;

  // Reference model state: last committed result and flags.
  logic [15:0] mOut;
  logic        mValid;
  logic        mCarry;
  logic        mOvf;

  vector_t vecs[$];

  always #5 clk = ~clk;

  alu16 dut (
    .clk       (clk),
    .rst       (rst),
    .in1       (in1),
    .in2       (in2),
    .sel       (sel),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample just after it.
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] a,
                               input logic [15:0] b, input logic [1:0] s);
    rst      = r;
    in_valid = v;
    in1      = a;
    in2      = b;
    sel      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [15:0] eOut, input logic eValid,
                          input logic eCarry, input logic eOvf, input logic eZero, input logic eNeg);
    checkOutput({tag, ".out"}, out, eOut);
    checkOutput({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, eValid});
    checkOutput({tag, ".carry"}, {15'd0, carry}, {15'd0, eCarry & FlagsEn});
    checkOutput({tag, ".overflow"}, {15'd0, overflow}, {15'd0, eOvf & FlagsEn});
    checkOutput({tag, ".zero"}, {15'd0, zero}, {15'd0, eZero & FlagsEn});
    checkOutput({tag, ".negative"}, {15'd0, negative}, {15'd0, eNeg & FlagsEn});
  endtask

  // Arithmetic model using plain integer math on unsigned and signed views.
  task automatic modelStep(input logic r, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] s);
    int ua, ub, sa, sb, ures, sres;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (r) begin
      mOut = 16'h0; mValid = 1'b0; mCarry = 1'b0; mOvf = 1'b0;
    end else if (!v) begin
      mValid = 1'b0;
    end else begin
      mValid = 1'b1;
      case (s)
        2'd0: begin
          ures = ua + ub; sres = sa + sb;
          mOut = ures[15:0]; mCarry = (ures > 65535);
          mOvf = (sres > 32767) || (sres < -32768);
        end
        2'd1: begin
          ures = ua - ub; sres = sa - sb;
          mOut = ures[15:0]; mCarry = (ua >= ub);
          mOvf = (sres > 32767) || (sres < -32768);
        end
        2'd2: begin mOut = a & b; mCarry = 1'b0; mOvf = 1'b0; end
        default: begin mOut = a | b; mCarry = 1'b0; mOvf = 1'b0; end
      endcase
    end
  endtask

  function automatic vector_t mk(logic r, logic v, logic [15:0] a, logic [15:0] b, logic [1:0] s,
                                 logic [15:0] eo, logic ev, logic ec, logic eov, logic ez, logic en);
    vector_t t;
    t.rst = r; t.valid = v; t.a = a; t.b = b; t.sel = s;
    t.expOut = eo; t.expValid = ev; t.expCarry = ec; t.expOvf = eov; t.expZero = ez; t.expNeg = en;
    return t;
  endfunction

  initial begin
    // rst valid a b sel | out valid carry ovf zero neg
    vecs.push_back(mk(1, 0, 16'h0000, 16'h0000, 2'd0, 16'h0000, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 16'h0000, 2'd0, 16'h0000, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 16'd400,  16'd123,  2'd0, 16'd523,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'd400,  16'd123,  2'd1, 16'd277,  1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'd400,  16'd123,  2'd2, 16'h0010, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'd400,  16'd123,  2'd3, 16'h01FB, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'hFFFF, 16'h0001, 2'd0, 16'h0000, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 16'h7FFF, 16'h0001, 2'd0, 16'h8000, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 16'h8000, 16'h0001, 2'd1, 16'h7FFF, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'd5,    16'd7,    2'd1, 16'hFFFE, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 16'd7,    16'd5,    2'd1, 16'h0002, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'hAAAA, 16'h5555, 2'd3, 16'h0002, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'hFFFF, 16'hFFFF, 2'd0, 16'h0002, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0001, 16'h0001, 2'd0, 16'h0000, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 16'h1234, 16'h0001, 2'd0, 16'h1235, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].sel);
      checkAll($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expValid,
               vecs[i].expCarry, vecs[i].expOvf, vecs[i].expZero, vecs[i].expNeg);
    end

    // Randomized phase, starting from a known reset state in both DUT and model.
    modelStep(1'b1, 1'b0, 16'h0, 16'h0, 2'd0);
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 2'd0);
    for (int i = 0; i < 400; i++) begin
      logic        r, v;
      logic [15:0] a, b;
      logic [1:0]  s;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
      s = 2'($urandom_range(0, 3));
      applyStimulus(r, v, a, b, s);
      modelStep(r, v, a, b, s);
      checkAll($sformatf("rnd%0d", i), mOut, mValid, mCarry, mOvf, (mOut == 16'h0), mOut[15]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
